fetch: RTL and testbench
========================

# fetch

Instruction fetch stage of the MIPS pipeline, directly upstream of decode. Holds the PC, issues single-outstanding word requests to instruction memory over a req/ack handshake, and buffers returned words with their PCs in a 2-entry queue. Presents `{instr, pc}` with a valid strobe that drives decode's instruction and clock-enable inputs. Honours downstream stall and flushes on branch/jump redirect.

## Interface
- `AWIDTH`, 32: PC / instruction-memory address width.
- `IWIDTH`, 32: instruction width.
- `PC_RESET`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: output queue entries. Fixed at 2.

- `f_clk`  in  1  clock. All state changes on the rising edge.
- `f_rst`  in  1  reset. Asynchronous, active-high.
- `f_i_stall`  in  1  downstream not accepting. Head entry is held.
- `f_i_redirect`  in  1  flush and restart at `f_i_redirect_pc`.
- `f_i_redirect_pc`  in  AWIDTH  redirect target. Bits [1:0] are ignored and treated as 00.
- `f_o_imem_req`  out  1  memory request, registered.
- `f_o_imem_addr`  out  AWIDTH  request address, registered, word aligned.
- `f_i_imem_ack`  in  1  response valid this cycle. May assert in the same cycle req is first seen.
- `f_i_imem_rdata`  in  IWIDTH  instruction word. Valid only when ack=1.
- `f_o_instr`  out  IWIDTH  queue head instruction. Zero when `f_o_ce`=0.
- `f_o_pc`  out  AWIDTH  PC of head instruction. Zero when `f_o_ce`=0.
- `f_o_ce`  out  1  head valid (queue non-empty).

## Operation
- Reset values:
  - req=0, addr=`PC_RESET`
  - queue empty, so ce=0, instr=0, pc=0
  - state=IDLE, internal pc=`PC_RESET`
- Pop condition: pop = ce & !stall.
- Space condition: space = (count − pop) < DEPTH.
- Handshake:
  - Once raised, req and addr stay stable until the cycle ack=1.
  - No abort, no second outstanding request.
  - Memory must tolerate req dropping on reset.
- FSM states:
  - IDLE: req=0.
    - If redirect: flush, addr←target, req←1, go to FETCH.
    - Else if space: addr←pc, req←1, go to FETCH.
  - FETCH: req=1.
    - On ack without redirect: push {rdata, addr}, pc←addr+4.
      - If (count+1−pop) < DEPTH: addr←addr+4, req stays 1, stay in FETCH.
      - Else: req←0, go to IDLE.
    - On redirect with ack: discard rdata, flush, addr←target, req←1, stay in FETCH.
    - On redirect without ack: flush, pc←target, go to DRAIN.
  - DRAIN: req stays 1 on the old address.
    - On ack: discard rdata, addr←pc, req←1, go to FETCH.
    - A further redirect in DRAIN overwrites pc, so the latest target wins.
- Redirect overrides stall and pop: the queue is emptied, including the head.
- Never overflows: a request is only issued when a free slot is guaranteed at ack time.
- PC arithmetic: +4 modulo 2^AWIDTH. `FFFF_FFFC` wraps to 0.

## Timing
- Zero-wait memory (ack in same cycle as req): sustained 1 instruction/cycle with stall=0.
- Reset release to first ce=1: 2 edges.
  - Edge 1: req/addr registered.
  - Edge 2: push.
- Ack to head visible: 1 edge. The pushed entry appears on the next cycle if the queue was empty.
- Redirect to first new-target instruction on ce (zero-wait memory):
  - From IDLE or FETCH-with-ack: 2 edges.
  - From DRAIN: 1 extra cycle per wait cycle of the old request.
- Stall held with queue full: req drops after the ack that fills the queue. The head remains stable for the whole stall.

## Structure
- Add to `header.vh`:
  - State encodings `FETCH_IDLE`, `FETCH_REQ`, `FETCH_DRAIN` (2 bits).
  - `PC_STEP` (4).
- Sub-module `fetch_fifo`: 2-entry synchronous FIFO of {pc, instr}.
  - Ports: push, pop, flush, count, head.
  - Flush has priority over push and pop.
- The top level holds the FSM, pc, and the request registers.

## Test plan
- Reset then zero-wait memory with rdata = addr ^ 32'hA5A5_0000, stall=0 → ce rises 2 edges after reset release. pc sequence 0, 4, 8, …, one per cycle; instr matches.
- Stall=1 for 6 cycles from steady state → queue holds 2 entries, req=0 after the filling ack. Head pc/instr are unchanged. Release → pcs continue with no gap or duplicate.
- Memory with 3-cycle ack latency, redirect to 32'h0000_0100 while the request for 0x8 is pending → req/addr stay 0x8 until ack. The 0x8 data is never presented. Next ce shows pc=0x100.
- Redirect coincident with ack and with stall=1, queue full → queue empty next cycle (ce=0). rdata is discarded. Subsequent pcs are 0x100, 0x104.
- Redirect to 32'hFFFF_FFFB → first fetch at FFFF_FFF8. Next pcs are FFFF_FFFC, then 0000_0000.
- Assert f_rst mid-FETCH with ack pending → all outputs are at reset values immediately, without waiting for a clock. Fetch restarts at `PC_RESET` after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encodings and constants for the fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry {pc, instr} queue between fetch and decode
module fetch_fifo #(
    parameter int AWIDTH = 32,
    parameter int IWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [AWIDTH-1:0] push_pc,
    input  logic [IWIDTH-1:0] push_instr,
    output logic [1:0]        count,
    output logic [AWIDTH-1:0] head_pc,
    output logic [IWIDTH-1:0] head_instr
);

    logic [AWIDTH-1:0] pc_mem    [2];
    logic [IWIDTH-1:0] instr_mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    assign do_pop     = pop && (count_q != 2'd0);
    assign do_push    = push && ((count_q != 2'd2) || do_pop);
    assign count      = count_q;
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    // Storage needs no reset: the head is only looked at while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    // Pointer and occupancy tracking; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: pc, imem request FSM and output queue
module fetch
    import fetch_pkg::*;
#(
    parameter int                AWIDTH   = 32,
    parameter int                IWIDTH   = 32,
    parameter logic [AWIDTH-1:0] PC_RESET = 32'h0000_0000,
    parameter int                DEPTH    = 2
) (
    input  logic              f_clk,
    input  logic              f_rst,
    input  logic              f_i_stall,
    input  logic              f_i_redirect,
    input  logic [AWIDTH-1:0] f_i_redirect_pc,
    output logic              f_o_imem_req,
    output logic [AWIDTH-1:0] f_o_imem_addr,
    input  logic              f_i_imem_ack,
    input  logic [IWIDTH-1:0] f_i_imem_rdata,
    output logic [IWIDTH-1:0] f_o_instr,
    output logic [AWIDTH-1:0] f_o_pc,
    output logic              f_o_ce
);

    localparam logic [2:0]        DEPTH_W = 3'(DEPTH);
    localparam logic [AWIDTH-1:0] STEP    = AWIDTH'(PC_STEP);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [AWIDTH-1:0] pc_q;
    logic [AWIDTH-1:0] pc_next;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] addr_next;
    logic              req_q;
    logic              req_next;
    logic [AWIDTH-1:0] target;
    logic              push;
    logic              flush;
    logic              pop;
    logic              space;
    logic [1:0]        count;
    logic [2:0]        level_after_pop;
    logic [2:0]        level_after_push;
    logic [AWIDTH-1:0] head_pc;
    logic [IWIDTH-1:0] head_instr;

    assign target           = {f_i_redirect_pc[AWIDTH-1:2], 2'b00};
    assign f_o_ce           = (count != 2'd0);
    assign pop              = f_o_ce && !f_i_stall;
    assign level_after_pop  = {1'b0, count} - {2'b00, pop};
    assign level_after_push = {1'b0, count} + 3'd1 - {2'b00, pop};
    assign space            = (level_after_pop < DEPTH_W);

    assign f_o_imem_req  = req_q;
    assign f_o_imem_addr = addr_q;
    assign f_o_instr     = f_o_ce ? head_instr : '0;
    assign f_o_pc        = f_o_ce ? head_pc : '0;

    fetch_fifo #(
        .AWIDTH (AWIDTH),
        .IWIDTH (IWIDTH)
    ) u_fifo (
        .clk        (f_clk),
        .rst        (f_rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_pc    (addr_q),
        .push_instr (f_i_imem_rdata),
        .count      (count),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    // State, pc and request registers.
    always_ff @(posedge f_clk or posedge f_rst) begin
        if (f_rst) begin
            state  <= FETCH_IDLE;
            pc_q   <= PC_RESET;
            addr_q <= PC_RESET;
            req_q  <= 1'b0;
        end else begin
            state  <= state_next;
            pc_q   <= pc_next;
            addr_q <= addr_next;
            req_q  <= req_next;
        end
    end

    // Next-state logic: requests are only launched when a slot is free at ack time,
    // and an outstanding request is never abandoned (DRAIN swallows its data).
    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        addr_next  = addr_q;
        req_next   = req_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            FETCH_IDLE: begin
                req_next = 1'b0;
                if (f_i_redirect) begin
                    flush      = 1'b1;
                    pc_next    = target;
                    addr_next  = target;
                    req_next   = 1'b1;
                    state_next = FETCH_REQ;
                end else if (space) begin
                    addr_next  = pc_q;
                    req_next   = 1'b1;
                    state_next = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (f_i_redirect) begin
                    flush   = 1'b1;
                    pc_next = target;
                    if (f_i_imem_ack) begin
                        addr_next = target;
                        req_next  = 1'b1;
                    end else begin
                        state_next = FETCH_DRAIN;
                    end
                end else if (f_i_imem_ack) begin
                    push    = 1'b1;
                    pc_next = addr_q + STEP;
                    if (level_after_push < DEPTH_W) begin
                        addr_next = addr_q + STEP;
                    end else begin
                        req_next   = 1'b0;
                        state_next = FETCH_IDLE;
                    end
                end
            end
            FETCH_DRAIN: begin
                if (f_i_redirect) begin
                    flush   = 1'b1;
                    pc_next = target;
                end
                if (f_i_imem_ack) begin
                    addr_next  = f_i_redirect ? target : pc_q;
                    req_next   = 1'b1;
                    state_next = FETCH_REQ;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = FETCH_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed vector bench for the fetch stage
module tb_fetch;

    logic        f_clk = 1'b0;
    logic        f_rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ce;

    int lat = 0;
    int wait_cnt = 0;
    int passed = 0;
    int total = 0;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    typedef struct {
        logic        stall;
        logic        ce;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[14];

    fetch dut (
        .f_clk           (f_clk),
        .f_rst           (f_rst),
        .f_i_stall       (stall),
        .f_i_redirect    (redirect),
        .f_i_redirect_pc (redirect_pc),
        .f_o_imem_req    (req),
        .f_o_imem_addr   (addr),
        .f_i_imem_ack    (ack),
        .f_i_imem_rdata  (rdata),
        .f_o_instr       (instr),
        .f_o_pc          (pc),
        .f_o_ce          (ce)
    );

    always #5 f_clk = ~f_clk;

    // Memory model: ack after lat wait cycles, data = addr ^ KEY.
    always @(posedge f_clk or posedge f_rst) begin
        if (f_rst) wait_cnt <= 0;
        else if (req && !ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign ack   = req && (wait_cnt >= lat);
    assign rdata = ack ? (addr ^ KEY) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge f_clk);
        #1;
    endtask

    task automatic do_reset(input int latency, input logic st);
        f_rst = 1'b1;
        redirect = 1'b0;
        stall = st;
        lat = latency;
        repeat (2) step();
        f_rst = 1'b0;
    endtask

    task automatic chk_head(input string name, input logic [31:0] exp_pc);
        chk({name, "_ce"}, {31'b0, ce}, 32'd1);
        chk({name, "_pc"}, pc, exp_pc);
        chk({name, "_instr"}, instr, exp_pc ^ KEY);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 32'h00, 1'b1, 32'h04};
        vecs[2]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h08};
        vecs[3]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0C};
        vecs[4]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h10};
        for (int i = 5; i < 11; i++) vecs[i] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h10};
        vecs[11] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h14};
        vecs[12] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h18};
        vecs[13] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h1C};

        // Reset values, then streaming and a 6-cycle stall with zero-wait memory
        f_rst = 1'b1;
        repeat (2) step();
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_ce", {31'b0, ce}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        do_reset(0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            stall = vecs[i].stall;
            step();
            chk($sformatf("v%0d_ce", i), {31'b0, ce}, {31'b0, vecs[i].ce});
            chk($sformatf("v%0d_pc", i), pc, vecs[i].ce ? vecs[i].pc : 32'h0);
            chk($sformatf("v%0d_instr", i), instr, vecs[i].ce ? (vecs[i].pc ^ KEY) : 32'h0);
            chk($sformatf("v%0d_req", i), {31'b0, req}, {31'b0, vecs[i].req});
            chk($sformatf("v%0d_addr", i), addr, vecs[i].addr);
        end
        stall = 1'b0;

        // Redirect while the 0x8 request waits on a 3-cycle memory
        do_reset(3, 1'b0);
        for (int i = 0; i < 40 && !(req && addr == 32'h8); i++) step();
        chk("slow_reach_8", addr, 32'h8);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("drain_req", {31'b0, req}, 32'd1);
        chk("drain_addr", addr, 32'h8);
        chk("drain_ce", {31'b0, ce}, 32'd0);
        for (int i = 0; i < 10 && !ack; i++) begin
            step();
            chk("drain_hold_addr", addr, 32'h8);
            chk("drain_hold_ce", {31'b0, ce}, 32'd0);
        end
        step();
        chk("drain_new_addr", addr, 32'h100);
        chk("drain_new_ce", {31'b0, ce}, 32'd0);
        for (int i = 0; i < 10 && !ce; i++) step();
        chk_head("drain_first", 32'h100);

        // Redirect coincident with ack while stalled with a non-empty queue
        do_reset(0, 1'b1);
        step();
        step();
        chk_head("stl_head0", 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        stall = 1'b0;
        chk("rda_ce", {31'b0, ce}, 32'd0);
        chk("rda_pc", pc, 32'h0);
        chk("rda_addr", addr, 32'h100);
        step();
        chk_head("rda_p100", 32'h100);
        step();
        chk_head("rda_p104", 32'h104);

        // Unaligned redirect near the top of the address space wraps to 0
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFB;
        step();
        redirect = 1'b0;
        chk("wrap_addr", addr, 32'hFFFF_FFF8);
        chk("wrap_ce", {31'b0, ce}, 32'd0);
        step();
        chk_head("wrap_f8", 32'hFFFF_FFF8);
        step();
        chk_head("wrap_fc", 32'hFFFF_FFFC);
        step();
        chk_head("wrap_00", 32'h0000_0000);

        // Asynchronous reset in the middle of a pending request
        lat = 3;
        repeat (5) step();
        chk("pre_rst_req", {31'b0, req}, 32'd1);
        #3;
        f_rst = 1'b1;
        #1;
        chk("arst_req", {31'b0, req}, 32'd0);
        chk("arst_addr", addr, 32'h0);
        chk("arst_ce", {31'b0, ce}, 32'd0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_instr", instr, 32'h0);
        lat = 0;
        step();
        f_rst = 1'b0;
        step();
        chk("rel_req", {31'b0, req}, 32'd1);
        chk("rel_addr", addr, 32'h0);
        chk("rel_ce", {31'b0, ce}, 32'd0);
        step();
        chk_head("rel_first", 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
